// File: rtl/ex_pkg.sv
// Shared encodings for the MIPS execute stage: ALU op classes, ALU control
// codes, R-type funct values and control-field bit positions.
package ex_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ADD2  = 2'b11;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_NOR  = 4'b1100,
        ALU_NONE = 4'b1111
    } alu_ctrl_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    localparam int unsigned WB_W          = 2;
    localparam int unsigned WB_REGWRITE   = 1;
    localparam int unsigned WB_MEMTOREG   = 0;

    localparam int unsigned MEM_W         = 3;
    localparam int unsigned MEM_BRANCH    = 2;
    localparam int unsigned MEM_MEMREAD   = 1;
    localparam int unsigned MEM_MEMWRITE  = 0;

    localparam int unsigned EXE_W         = 4;
    localparam int unsigned EXE_REGDST    = 3;
    localparam int unsigned EXE_ALUOP_HI  = 2;
    localparam int unsigned EXE_ALUOP_LO  = 1;
    localparam int unsigned EXE_ALUSRC    = 0;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU control decode and ALU; unknown funct yields a zero result.
module ex_alu
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [1:0]        aluop_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    alu_ctrl_e ctrl;

    always_comb begin
        ctrl = ALU_NONE;
        unique case (aluop_i)
            ALUOP_ADD:   ctrl = ALU_ADD;
            ALUOP_SUB:   ctrl = ALU_SUB;
            ALUOP_ADD2:  ctrl = ALU_ADD;
            ALUOP_RTYPE: begin
                case (funct_i)
                    FUNCT_ADD: ctrl = ALU_ADD;
                    FUNCT_SUB: ctrl = ALU_SUB;
                    FUNCT_AND: ctrl = ALU_AND;
                    FUNCT_OR:  ctrl = ALU_OR;
                    FUNCT_SLT: ctrl = ALU_SLT;
                    FUNCT_NOR: ctrl = ALU_NOR;
                    default:   ctrl = ALU_NONE;
                endcase
            end
            default:     ctrl = ALU_NONE;
        endcase
    end

    always_comb begin
        result_o = '0;
        case (ctrl)
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_NOR: result_o = ~(a_i | b_i);
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand mux, ALU, branch adder, destination select and
// the EX/MEM pipeline register with stall/flush.
module ex_stage
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_stall,
    input  logic                  ex_flush,
    input  logic [WB_W-1:0]       id_ex_wb,
    input  logic [MEM_W-1:0]      id_ex_mem,
    input  logic [EXE_W-1:0]      id_ex_execute,
    input  logic [DATA_W-1:0]     id_ex_npc,
    input  logic [DATA_W-1:0]     id_ex_readdat1,
    input  logic [DATA_W-1:0]     id_ex_readdat2,
    input  logic [DATA_W-1:0]     id_ex_sign_ext,
    input  logic [REG_ADDR_W-1:0] id_ex_instr_bits_20_16,
    input  logic [REG_ADDR_W-1:0] id_ex_instr_bits_15_11,
    output logic [WB_W-1:0]       ex_mem_wb,
    output logic [MEM_W-1:0]      ex_mem_m,
    output logic                  ex_mem_valid,
    output logic [DATA_W-1:0]     ex_mem_branch_target,
    output logic                  ex_mem_zero,
    output logic [DATA_W-1:0]     ex_mem_alu_result,
    output logic [DATA_W-1:0]     ex_mem_rdata2,
    output logic [REG_ADDR_W-1:0] ex_mem_write_reg
);

    logic [DATA_W-1:0]     alu_b;
    logic [DATA_W-1:0]     alu_result;
    logic                  alu_zero;
    logic [DATA_W-1:0]     branch_target;
    logic [REG_ADDR_W-1:0] write_reg;

    logic [WB_W-1:0]       wb_q;
    logic [MEM_W-1:0]      m_q;
    logic                  valid_q;
    logic [DATA_W-1:0]     target_q;
    logic                  zero_q;
    logic [DATA_W-1:0]     result_q;
    logic [DATA_W-1:0]     rdata2_q;
    logic [REG_ADDR_W-1:0] write_reg_q;

    assign alu_b = id_ex_execute[EXE_ALUSRC] ? id_ex_sign_ext : id_ex_readdat2;

    // Top two immediate bits fall off the word-offset shift.
    assign branch_target = id_ex_npc + {id_ex_sign_ext[DATA_W-3:0], 2'b00};

    assign write_reg = id_ex_execute[EXE_REGDST] ? id_ex_instr_bits_15_11
                                                 : id_ex_instr_bits_20_16;

    ex_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .aluop_i  (id_ex_execute[EXE_ALUOP_HI:EXE_ALUOP_LO]),
        .funct_i  (id_ex_sign_ext[5:0]),
        .a_i      (id_ex_readdat1),
        .b_i      (alu_b),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst || ex_flush) begin
            wb_q        <= '0;
            m_q         <= '0;
            valid_q     <= 1'b0;
            target_q    <= '0;
            zero_q      <= 1'b0;
            result_q    <= '0;
            rdata2_q    <= '0;
            write_reg_q <= '0;
        end else if (!ex_stall) begin
            wb_q        <= id_ex_wb;
            m_q         <= id_ex_mem;
            valid_q     <= 1'b1;
            target_q    <= branch_target;
            zero_q      <= alu_zero;
            result_q    <= alu_result;
            rdata2_q    <= id_ex_readdat2;
            write_reg_q <= write_reg;
        end
    end

    assign ex_mem_wb            = wb_q;
    assign ex_mem_m             = m_q;
    assign ex_mem_valid         = valid_q;
    assign ex_mem_branch_target = target_q;
    assign ex_mem_zero          = zero_q;
    assign ex_mem_alu_result    = result_q;
    assign ex_mem_rdata2        = rdata2_q;
    assign ex_mem_write_reg     = write_reg_q;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Consumes the ID/EX register outputs: control fields, npc, both read-data values, the sign-extended immediate, and rt/rd.
- Performs ALU control decode, ALU-source mux, ALU operation, branch-target add and destination-register select.
- Registers all results into the EX/MEM pipeline register that feeds the MEM stage.
- Supports hazard-unit stall (hold) and flush (bubble insertion).

Parameters:
DATA_W, 32, datapath width
REG_ADDR_W, 5, register-address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; one clock; reset is synchronous and active-low
ex_stall  in  1  hold EX/MEM register contents
ex_flush  in  1  load bubble into EX/MEM register
id_ex_wb  in  2  [1]=regwrite, [0]=memtoreg
id_ex_mem  in  3  [2]=branch, [1]=memread, [0]=memwrite
id_ex_execute  in  4  [3]=regdst, [2:1]=aluop, [0]=alusrc
id_ex_npc  in  DATA_W  PC+4 of instruction
id_ex_readdat1  in  DATA_W  rs value
id_ex_readdat2  in  DATA_W  rt value
id_ex_sign_ext  in  DATA_W  sign-extended immediate; [5:0]=funct
id_ex_instr_bits_20_16  in  REG_ADDR_W  rt
id_ex_instr_bits_15_11  in  REG_ADDR_W  rd
ex_mem_wb  out  2  registered wb control
ex_mem_m  out  3  registered mem control
ex_mem_valid  out  1  slot holds a real instruction
ex_mem_branch_target  out  DATA_W  npc + (sign_ext << 2)
ex_mem_zero  out  1  ALU result == 0
ex_mem_alu_result  out  DATA_W  ALU result
ex_mem_rdata2  out  DATA_W  store data (readdat2 passthrough)
ex_mem_write_reg  out  REG_ADDR_W  destination register

Behaviour:
- All outputs registered; 1-cycle latency from ID/EX inputs to EX/MEM outputs.
- Priority at each rising edge: rst==0 > ex_flush > ex_stall > normal load.
- Reset: all outputs 0, including valid, zero, target, result, rdata2 and write_reg.
- Flush: ex_mem_wb=0, ex_mem_m=0, ex_mem_valid=0, all data fields 0. Flush overrides a simultaneous stall.
- Stall: every output holds its previous value; inputs are ignored.
- Normal load: ex_mem_valid=1, and every field takes its computed value.

ALU control (4-bit code):
- aluop 00 -> ADD 0010
- aluop 01 -> SUB 0110
- aluop 11 -> ADD 0010
- aluop 10 -> decode funct:
  - 100000 ADD
  - 100010 SUB
  - 100100 AND 0000
  - 100101 OR 0001
  - 101010 SLT 0111
  - 100111 NOR 1100
  - any other funct -> 1111

ALU:
- Operand A = readdat1.
- Operand B = alusrc ? sign_ext : readdat2.
- ADD/SUB wrap mod 2^DATA_W; no overflow trap.
- SLT is signed two's-complement compare; result 1 or 0, zero-extended.
- Code 1111 -> result 0.
- zero = (result == 0), computed from the same result that is registered.

Other datapath:
- Branch target = npc + {sign_ext[DATA_W-3:0],2'b00}, mod 2^DATA_W; discarded upper bits are ignored.
- write_reg = regdst ? instr_bits_15_11 : instr_bits_20_16.
- rdata2 always takes readdat2, regardless of alusrc.
- Reset asserted mid-stream: the next edge clears all outputs; the in-flight instruction is lost, with no partial update.
- No internal state beyond the EX/MEM register; combinational paths are X-free for all input values.

Decomposition:
- Package ex_pkg holds:
  - aluop encodings
  - ALU control codes (AND/OR/ADD/SUB/SLT/NOR/NONE)
  - funct constants
  - bit-index constants for the wb, mem and execute control fields
- One sub-module, ex_alu: pure combinational ALU control decode plus ALU.
  - Inputs: aluop, funct, A, B.
  - Outputs: result, zero.
- ex_stage contains the operand mux, branch adder, regdst mux and EX/MEM register.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random inputs -> every output 0. Release -> the first load appears one edge later.
- R-type add: aluop=10, funct=100000, alusrc=0, readdat1=7, readdat2=5, regdst=1, rd=9 -> alu_result=12, zero=0, write_reg=9, valid=1.
- lw address: aluop=00, alusrc=1, readdat1=0x1000, sign_ext=0xFFFFFFFC, rt=4, regdst=0 -> alu_result=0x00000FFC, write_reg=4, m passthrough 3'b010.
- beq taken: aluop=01, readdat1=readdat2=0x55, npc=0x40, sign_ext=3 -> zero=1, alu_result=0, branch_target=0x4C.
- SLT signed: readdat1=0xFFFFFFFF, readdat2=1, funct=101010 -> result=1. Swap operands -> result=0, zero=1.
- Stall/flush: load an instruction, assert ex_stall for 3 cycles with new inputs -> outputs unchanged. Then assert ex_flush and ex_stall together -> wb=0, m=0, valid=0.
